adder16_serial: RTL

ADDER16_SERIAL -- requirements
Module: adder16_serial

---
 rtl/adder16_serial.sv | 138 +++++++++++++
 1 files changed

// File: rtl/adder16_serial.sv
// rtl/adder16_serial.sv - nibble-serial adder with registered sum, carry-out and overflow
//
// Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in using a single
// 4-bit adder, one nibble per clock, LSB nibble first.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   asynchronous active-low reset
//   START  in   begin an addition (accepted only in IDLE)
//   A, B   in   W-bit operands, latched with an accepted START
//   Cin    in   carry-in to nibble 0, latched with an accepted START
//   BUSY   out  high in RUN and DONE
//   DONE   out  one-cycle completion pulse
//   S      out  W-bit registered sum
//   Cout   out  registered carry out of the top nibble
//   OVF    out  registered two's-complement overflow

module adder16_serial #(
    parameter int NIBBLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [4*NIBBLES-1:0] S,
    output logic                 Cout,
    output logic                 OVF
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   s_q, s_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [4:0]     nib_sum;
    logic           last_nib;

    // Operands are shifted right each RUN cycle, so the nibble being added
    // is always in bits [3:0]; on the last nibble bit 3 is the operand sign.
    always_comb begin
        nib_sum  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        last_nib = (cnt_q == CW'(NIBBLES - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                // Sum nibbles enter at the top and shift down, so after the
                // last nibble the accumulator holds the sum in place.
                acc_d   = (acc_q >> 4) | (W'(nib_sum[3:0]) << (W - 4));
                carry_d = nib_sum[4];
                cnt_d   = cnt_q + CW'(1);
                if (last_nib) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    s_d     = acc_d;
                    cout_d  = nib_sum[4];
                    ovf_d   = (a_q[3] == b_q[3]) && (nib_sum[3] != a_q[3]);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_DONE);
    assign S    = s_q;
    assign Cout = cout_q;
    assign OVF  = ovf_q;

endmodule
